// File: rtl/atm_pkg.sv
// Shared key codes, operation codes, FSM states and digit limits for the ATM keypad front end.
package atm_pkg;

  localparam logic [3:0] KEY_ENTER  = 4'hA;
  localparam logic [3:0] KEY_CANCEL = 4'hB;
  localparam logic [3:0] KEY_LANG   = 4'hC;
  localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;

  localparam logic [2:0] OP_BALANCE    = 3'd0;
  localparam logic [2:0] OP_WITHDRAW   = 3'd1;
  localparam logic [2:0] OP_DEPOSIT    = 3'd2;
  localparam logic [2:0] OP_CHANGE_PIN = 3'd3;

  localparam int PIN_DIGITS = 4;
  localparam int AMT_DIGITS = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC,
    ST_PIN,
    ST_OPSEL,
    ST_AMOUNT,
    ST_NEWPIN,
    ST_ISSUE,
    ST_RESULT
  } state_t;

endpackage

// File: rtl/atm_bcd_accum.sv
// Keypad digit accumulator: packs up to MAX_DIGITS digits either as BCD (shift left)
// or as a binary decimal value (x10 + d); extra digits are dropped.
module atm_bcd_accum
  import atm_pkg::*;
#(
  parameter int MAX_DIGITS = 4,
  parameter bit BINARY     = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        load,
  input  logic [3:0]  digit,
  output logic [15:0] value,
  output logic [2:0]  count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
      count <= '0;
    end else if (clear) begin
      value <= '0;
      count <= '0;
    end else if (load && (count < 3'(MAX_DIGITS))) begin
      // at most 4 decimal digits, so the binary form never exceeds 9999
      value <= BINARY ? (value * 16'd10) + 16'(digit) : {value[11:0], digit};
      count <= count + 3'd1;
    end
  end

endmodule

// File: rtl/atm_keypad_frontend.sv
// Keypad-to-ATM request front end: collects one transaction from key strokes, holds the
// request for a fixed response latency, then captures the core's success flag and balance.
module atm_keypad_frontend
  import atm_pkg::*;
#(
  parameter int unsigned RSP_LATENCY    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        atm_success,
  input  logic [15:0] atm_balance,
  output logic [2:0]  operation,
  output logic [3:0]  acc_num,
  output logic [15:0] pin,
  output logic [15:0] Newpin,
  output logic [15:0] amount,
  output logic        language,
  output logic        req_valid,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic        result_ok,
  output logic [15:0] result_balance
);
  // state     | meaning
  // ST_IDLE   | no session; LANG toggles language, ENTER opens a session
  // ST_ACC    | collecting account digit
  // ST_PIN    | collecting 4 PIN digits
  // ST_OPSEL  | waiting for operation digit 0-3
  // ST_AMOUNT | collecting amount (withdraw/deposit)
  // ST_NEWPIN | collecting 4 new PIN digits
  // ST_ISSUE  | request presented to core, keys ignored
  // ST_RESULT | response captured and held

  localparam int LAT_W = (RSP_LATENCY > 1) ? $clog2(RSP_LATENCY) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RSP_LATENCY - 1);
  localparam logic [TMO_W-1:0] TMO_INIT = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t state_q, state_d;
  logic [LAT_W-1:0] lat_q;
  logic [TMO_W-1:0] tmo_q;
  logic acc_seen;
  logic [2:0] pin_cnt, npin_cnt, amt_cnt;
  logic clr, acc_ld, pin_ld, npin_ld, amt_ld, op_ld, capture, lang_tgl, abort_set;
  logic is_digit;

  assign is_digit  = key_code <= KEY_DIGIT_MAX;
  assign req_valid = (state_q == ST_ISSUE);
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    state_d   = state_q;
    clr       = 1'b0;
    acc_ld    = 1'b0;
    pin_ld    = 1'b0;
    npin_ld   = 1'b0;
    amt_ld    = 1'b0;
    op_ld     = 1'b0;
    capture   = 1'b0;
    lang_tgl  = 1'b0;
    abort_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (key_valid && key_code == KEY_LANG) lang_tgl = 1'b1;
        else if (key_valid && key_code == KEY_ENTER) state_d = ST_ACC;
      end
      ST_ISSUE: begin
        if (lat_q == '0) begin
          capture = 1'b1;
          state_d = ST_RESULT;
        end
      end
      default: begin
        // a key arriving on the timeout cycle keeps the session alive
        if ((key_valid && key_code == KEY_CANCEL) || (!key_valid && tmo_q == '0)) begin
          abort_set = 1'b1;
          clr       = 1'b1;
          state_d   = ST_IDLE;
        end else if (key_valid) begin
          case (state_q)
            ST_ACC: begin
              if (is_digit) acc_ld = 1'b1;
              else if (key_code == KEY_ENTER && acc_seen) state_d = ST_PIN;
            end
            ST_PIN: begin
              if (is_digit) pin_ld = 1'b1;
              else if (key_code == KEY_ENTER && pin_cnt == 3'(PIN_DIGITS)) state_d = ST_OPSEL;
            end
            ST_OPSEL: begin
              if (key_code <= 4'(OP_CHANGE_PIN)) begin
                op_ld = 1'b1;
                if (key_code[2:0] == OP_BALANCE) state_d = ST_ISSUE;
                else if (key_code[2:0] == OP_CHANGE_PIN) state_d = ST_NEWPIN;
                else state_d = ST_AMOUNT;
              end
            end
            ST_AMOUNT: begin
              if (is_digit) amt_ld = 1'b1;
              else if (key_code == KEY_ENTER && amt_cnt != 3'd0) state_d = ST_ISSUE;
            end
            ST_NEWPIN: begin
              if (is_digit) npin_ld = 1'b1;
              else if (key_code == KEY_ENTER && npin_cnt == 3'(PIN_DIGITS)) state_d = ST_ISSUE;
            end
            ST_RESULT: begin
              if (is_digit || key_code == KEY_ENTER) begin
                clr     = 1'b1;
                state_d = ST_IDLE;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      lat_q          <= '0;
      tmo_q          <= '0;
      acc_num        <= '0;
      acc_seen       <= 1'b0;
      operation      <= '0;
      language       <= 1'b0;
      done           <= 1'b0;
      aborted        <= 1'b0;
      result_ok      <= 1'b0;
      result_balance <= '0;
    end else begin
      state_q <= state_d;
      done    <= capture;
      aborted <= abort_set;
      if (lang_tgl) language <= ~language;
      if (clr) begin
        acc_num   <= '0;
        acc_seen  <= 1'b0;
        operation <= '0;
      end else begin
        if (acc_ld) begin
          acc_num  <= key_code;
          acc_seen <= 1'b1;
        end
        if (op_ld) operation <= key_code[2:0];
      end
      if (capture) begin
        result_ok      <= atm_success;
        result_balance <= atm_balance;
      end
      if (state_q != ST_ISSUE) lat_q <= LAT_INIT;
      else if (lat_q != '0) lat_q <= lat_q - 1'b1;
      if (state_q == ST_IDLE || state_q == ST_ISSUE || key_valid) tmo_q <= TMO_INIT;
      else if (tmo_q != '0) tmo_q <= tmo_q - 1'b1;
    end
  end

  atm_bcd_accum #(.MAX_DIGITS(PIN_DIGITS), .BINARY(1'b0)) u_pin (
    .clk(clk), .rst_n(rst_n), .clear(clr), .load(pin_ld), .digit(key_code),
    .value(pin), .count(pin_cnt)
  );

  atm_bcd_accum #(.MAX_DIGITS(PIN_DIGITS), .BINARY(1'b0)) u_newpin (
    .clk(clk), .rst_n(rst_n), .clear(clr), .load(npin_ld), .digit(key_code),
    .value(Newpin), .count(npin_cnt)
  );

  atm_bcd_accum #(.MAX_DIGITS(AMT_DIGITS), .BINARY(1'b1)) u_amount (
    .clk(clk), .rst_n(rst_n), .clear(clr), .load(amt_ld), .digit(key_code),
    .value(amount), .count(amt_cnt)
  );

endmodule

// File: tb/tb_atm_keypad_frontend.sv
// Bench for atm_keypad_frontend: directed sessions plus random key streams compared each cycle
// against a transaction-level reference model.
module tb_atm_keypad_frontend;

  localparam int RSP = 3;
  localparam int TMO = 16;
  localparam int M_IDLE = 0, M_ACC = 1, M_PIN = 2, M_OPSEL = 3, M_AMT = 4, M_NEWPIN = 5,
                 M_ISSUE = 6, M_RESULT = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = '0;
  logic        atm_success = 1'b0;
  logic [15:0] atm_balance = '0;
  logic [2:0]  operation;
  logic [3:0]  acc_num;
  logic [15:0] pin, Newpin, amount, result_balance;
  logic        language, req_valid, busy, done, aborted, result_ok;

  int n_cmp = 0;
  int n_bad = 0;

  int m_phase, m_acc, m_op, m_left, m_quiet, m_res_bal;
  bit m_acc_seen, m_lang, m_done, m_abort, m_res_ok;
  int m_pin[$];
  int m_npin[$];
  int m_amt[$];

  int force_succ = -1;
  logic [15:0] last_bal;

  atm_keypad_frontend #(.RSP_LATENCY(RSP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .atm_success(atm_success), .atm_balance(atm_balance), .operation(operation),
    .acc_num(acc_num), .pin(pin), .Newpin(Newpin), .amount(amount), .language(language),
    .req_valid(req_valid), .busy(busy), .done(done), .aborted(aborted),
    .result_ok(result_ok), .result_balance(result_balance)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int fold(input int q[$], input int base);
    int v = 0;
    foreach (q[i]) v = v * base + q[i];
    return v;
  endfunction

  task automatic end_session();
    m_phase = M_IDLE;
    m_acc = 0;
    m_acc_seen = 0;
    m_op = 0;
    m_pin.delete();
    m_npin.delete();
    m_amt.delete();
  endtask

  task automatic model_reset();
    end_session();
    m_lang = 0;
    m_done = 0;
    m_abort = 0;
    m_res_ok = 0;
    m_res_bal = 0;
    m_quiet = 0;
    m_left = 0;
  endtask

  task automatic enter_issue();
    m_phase = M_ISSUE;
    m_left = RSP;
  endtask

  task automatic model_step(input bit kv, input int kc, input bit succ, input int bal);
    bit active, digit;
    m_done = 0;
    m_abort = 0;
    digit = (kc <= 9);
    active = (m_phase != M_IDLE) && (m_phase != M_ISSUE);
    m_quiet = (active && !kv) ? m_quiet + 1 : 0;
    if (m_phase == M_IDLE) begin
      if (kv && kc == 12) m_lang = !m_lang;
      else if (kv && kc == 10) m_phase = M_ACC;
    end else if (m_phase == M_ISSUE) begin
      m_left--;
      if (m_left == 0) begin
        m_res_ok = succ;
        m_res_bal = bal;
        m_done = 1;
        m_phase = M_RESULT;
      end
    end else if ((kv && kc == 11) || m_quiet == TMO) begin
      m_abort = 1;
      end_session();
    end else if (kv) begin
      case (m_phase)
        M_ACC: begin
          if (digit) begin m_acc = kc; m_acc_seen = 1; end
          else if (kc == 10 && m_acc_seen) m_phase = M_PIN;
        end
        M_PIN: begin
          if (digit) begin if (m_pin.size() < 4) m_pin.push_back(kc); end
          else if (kc == 10 && m_pin.size() == 4) m_phase = M_OPSEL;
        end
        M_OPSEL: begin
          if (kc <= 3) begin
            m_op = kc;
            if (kc == 0) enter_issue();
            else if (kc == 3) m_phase = M_NEWPIN;
            else m_phase = M_AMT;
          end
        end
        M_AMT: begin
          if (digit) begin if (m_amt.size() < 4) m_amt.push_back(kc); end
          else if (kc == 10 && m_amt.size() > 0) enter_issue();
        end
        M_NEWPIN: begin
          if (digit) begin if (m_npin.size() < 4) m_npin.push_back(kc); end
          else if (kc == 10 && m_npin.size() == 4) enter_issue();
        end
        M_RESULT: if (kc <= 10) end_session();
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    check("req_valid", 32'(req_valid), 32'(m_phase == M_ISSUE));
    check("busy", 32'(busy), 32'(m_phase != M_IDLE));
    check("done", 32'(done), 32'(m_done));
    check("aborted", 32'(aborted), 32'(m_abort));
    check("operation", 32'(operation), 32'(m_op));
    check("acc_num", 32'(acc_num), 32'(m_acc));
    check("pin", 32'(pin), 32'(fold(m_pin, 16)));
    check("Newpin", 32'(Newpin), 32'(fold(m_npin, 16)));
    check("amount", 32'(amount), 32'(fold(m_amt, 10)));
    check("language", 32'(language), 32'(m_lang));
    check("result_ok", 32'(result_ok), 32'(m_res_ok));
    check("result_balance", 32'(result_balance), 32'(m_res_bal));
  endtask

  task automatic cycle(input bit kv, input int kc);
    key_valid = kv;
    key_code = 4'(kc);
    atm_success = (force_succ < 0) ? 1'($urandom) : 1'(force_succ);
    atm_balance = 16'($urandom);
    last_bal = atm_balance;
    @(posedge clk);
    model_step(kv, kc, atm_success, int'(atm_balance));
    @(negedge clk);
    compare_all();
  endtask

  task automatic send(input int s[$]);
    foreach (s[i]) cycle(1'b1, s[i]);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      cycle(1'b0, 0);
      n++;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    key_valid = 1'b0;
    key_code = '0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int seq[$];
    int n;
    int r, k, kc;
    bit kv;

    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    seq = '{12};
    send(seq);
    check("lang_toggle", 32'(language), 32'd1);

    seq = '{10, 5, 10, 1, 2, 3, 4, 10, 0};
    send(seq);
    check("bal_req_valid", 32'(req_valid), 32'd1);
    check("bal_acc", 32'(acc_num), 32'd5);
    check("bal_pin", 32'(pin), 32'h1234);
    check("bal_op", 32'(operation), 32'd0);
    wait_done(n);
    check("bal_latency", 32'(n), 32'(RSP));
    check("bal_result_balance", 32'(result_balance), 32'(last_bal));
    seq = '{4};
    send(seq);

    force_succ = 0;
    seq = '{10, 7, 10, 4, 3, 2, 1, 10, 1, 2, 5, 0, 10};
    send(seq);
    check("wd_amount", 32'(amount), 32'd250);
    check("wd_op", 32'(operation), 32'd1);
    wait_done(n);
    check("wd_result_ok", 32'(result_ok), 32'd0);
    force_succ = -1;
    seq = '{10};
    send(seq);

    seq = '{10, 2, 10, 5, 5, 5, 5, 10, 3, 9, 8, 7, 6, 10};
    send(seq);
    check("cp_newpin", 32'(Newpin), 32'h9876);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!req_valid) break;
      n++;
      cycle(1'b0, 0);
    end
    check("cp_req_cycles", 32'(n), 32'(RSP));
    seq = '{11};
    send(seq);

    seq = '{10, 6, 10, 1, 2, 3, 10};
    send(seq);
    check("pin3_value", 32'(pin), 32'h0123);
    check("pin3_busy", 32'(busy), 32'd1);
    seq = '{4, 5, 6};
    send(seq);
    check("pin6_value", 32'(pin), 32'h1234);
    seq = '{10, 1, 4, 2, 11};
    send(seq);
    check("cancel_aborted", 32'(aborted), 32'd1);
    check("cancel_busy", 32'(busy), 32'd0);
    check("cancel_amount", 32'(amount), 32'd0);
    cycle(1'b0, 0);
    check("cancel_pulse_len", 32'(aborted), 32'd0);

    seq = '{10, 1, 10, 1, 1, 1, 1, 10, 0, 11};
    send(seq);
    wait_done(n);
    check("issue_cancel_done", 32'(done), 32'd1);
    seq = '{10};
    send(seq);

    seq = '{10, 3, 10, 1};
    send(seq);
    n = 0;
    while (!aborted && n < 40) begin
      cycle(1'b0, 0);
      n++;
    end
    check("timeout_cycles", 32'(n), 32'(TMO));
    check("timeout_lang_kept", 32'(language), 32'd1);

    seq = '{10, 3, 10, 1, 2};
    send(seq);
    apply_reset();
    check("rst_lang", 32'(language), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) begin
        repeat (TMO + 2) cycle(1'b0, 0);
      end
      r = $urandom_range(99);
      kv = (r < 55);
      k = $urandom_range(99);
      if (k < 70) kc = $urandom_range(9);
      else if (k < 82) kc = 10;
      else if (k < 86) kc = 11;
      else if (k < 91) kc = 12;
      else kc = $urandom_range(15, 13);
      cycle(kv, kc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
